tlc_multi: RTL and testbench

TLC_MULTI -- requirements
Module: tlc_multi

---
 rtl/tlc_multi.sv | 204 ++++++++++++++++++++
 tb/tb_tlc_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tlc_multi.sv
// Multi-phase traffic light controller with a memory-mapped register port.
// Round-robin GREEN/YELLOW/RED service plus OFF, BLINK and MANUAL modes.
module tlc_multi #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  pvalid,
  input  logic                  prd_wr,
  input  logic [7:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic [NUM_PHASES-1:0] lamp_r,
  output logic [NUM_PHASES-1:0] lamp_y,
  output logic [NUM_PHASES-1:0] lamp_g,
  output logic [2:0]            cur_phase,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_BLANK = 3'd1, S_RED = 3'd2,
    S_YEL = 3'd3, S_GRN = 3'd4
  } st_t;

  typedef enum logic [2:0] {
    M_OFF = 3'd0, M_BLINK = 3'd1, M_MAN = 3'd2,
    M_HIGH = 3'd3, M_LOW = 3'd4
  } md_t;

  localparam logic [2:0] LAST = 3'(NUM_PHASES - 1);

  logic [2*CNT_W-1:0]   red_q, yel_q, grn_q;
  logic [2:0]           mode_q;
  logic [CNT_W-1:0]     blink_q;
  logic [31:0]          prdata_q;
  logic                 pready_q;
  st_t                  st_q, st_d;
  md_t                  pm_q, m;
  logic [2:0]           ph_q, ph_d;
  logic [CNT_W-1:0]     tm_q, tm_d;
  logic [NUM_PHASES-1:0] lr_q, ly_q, lg_q;
  logic [NUM_PHASES-1:0] lr_d, ly_d, lg_d, oh;
  logic [CNT_W-1:0]     r_t, y_t, g_t;
  logic [31:0]          rdata;
  logic                 lowsel;

  // Dwell of max(T,1) cycles: timer counts down to 0, then expires.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  function automatic logic [31:0] rd32(input logic [2*CNT_W-1:0] v);
    return (32'(v[CNT_W+:CNT_W]) << 16) | 32'(v[0+:CNT_W]);
  endfunction

  always_comb begin
    m      = (mode_q > 3'd4) ? M_OFF : md_t'(mode_q);
    lowsel = (m == M_LOW);
    r_t    = lowsel ? red_q[CNT_W+:CNT_W] : red_q[0+:CNT_W];
    y_t    = lowsel ? yel_q[CNT_W+:CNT_W] : yel_q[0+:CNT_W];
    g_t    = lowsel ? grn_q[CNT_W+:CNT_W] : grn_q[0+:CNT_W];
  end

  always_comb begin
    st_d = st_q;
    ph_d = ph_q;
    tm_d = tm_q;
    unique case (1'b1)
      (m == M_OFF): begin
        st_d = S_OFF;
        tm_d = '0;
      end
      (m == M_MAN): st_d = S_RED;
      (m == M_BLINK): begin
        if (pm_q != M_BLINK) begin
          st_d = S_YEL;
          tm_d = ld(blink_q);
        end else if (tm_q == '0) begin
          st_d = (st_q == S_YEL) ? S_BLANK : S_YEL;
          tm_d = ld(blink_q);
        end else begin
          tm_d = tm_q - CNT_W'(1);
        end
      end
      default: begin
        // Entering from a non-cycling mode parks on the last phase
        if (pm_q != M_HIGH && pm_q != M_LOW) begin
          st_d = S_RED;
          ph_d = LAST;
          tm_d = ld(r_t);
        end else if (tm_q == '0) begin
          unique case (st_q)
            S_GRN: begin
              st_d = S_YEL;
              tm_d = ld(y_t);
            end
            S_YEL: begin
              st_d = S_RED;
              tm_d = ld(r_t);
            end
            default: begin
              st_d = S_GRN;
              ph_d = (ph_q == LAST) ? 3'd0 : ph_q + 3'd1;
              tm_d = ld(g_t);
            end
          endcase
        end else begin
          tm_d = tm_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    oh   = NUM_PHASES'(1) << ph_d;
    lr_d = '0;
    ly_d = '0;
    lg_d = '0;
    unique case (st_d)
      S_RED: lr_d = '1;
      S_GRN: begin
        lg_d = oh;
        lr_d = ~oh;
      end
      S_YEL: begin
        if (m == M_BLINK) begin
          ly_d = '1;
        end else begin
          ly_d = oh;
          lr_d = ~oh;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (paddr)
      8'h00:   rdata = rd32(red_q);
      8'h04:   rdata = rd32(yel_q);
      8'h08:   rdata = rd32(grn_q);
      8'h0C:   rdata = 32'(mode_q);
      8'h10:   rdata = {21'b0, ph_q, 5'b0, st_q};
      8'h14:   rdata = 32'(blink_q);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      red_q    <= '0;
      yel_q    <= '0;
      grn_q    <= '0;
      mode_q   <= '0;
      blink_q  <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
    end else begin
      pready_q <= pvalid;
      if (pvalid && prd_wr) begin
        unique case (paddr)
          8'h00: red_q <= {pwdata[16+:CNT_W], pwdata[0+:CNT_W]};
          8'h04: yel_q <= {pwdata[16+:CNT_W], pwdata[0+:CNT_W]};
          8'h08: grn_q <= {pwdata[16+:CNT_W], pwdata[0+:CNT_W]};
          8'h0C: mode_q <= pwdata[2:0];
          8'h14: blink_q <= pwdata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (pvalid && !prd_wr) prdata_q <= rdata;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      st_q <= S_OFF;
      pm_q <= M_OFF;
      ph_q <= '0;
      tm_q <= '0;
      lr_q <= '0;
      ly_q <= '0;
      lg_q <= '0;
    end else begin
      st_q <= st_d;
      pm_q <= m;
      ph_q <= ph_d;
      tm_q <= tm_d;
      lr_q <= lr_d;
      ly_q <= ly_d;
      lg_q <= lg_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign lamp_r    = lr_q;
  assign lamp_y    = ly_q;
  assign lamp_g    = lg_q;
  assign cur_phase = ph_q;
  assign state     = st_q;

endmodule

// File: tb/tb_tlc_multi.sv
// Directed testbench for tlc_multi with hand-computed expectations.
// Rows pack {state, phase, lamp_r, lamp_y, lamp_g}.
module tb_tlc_multi;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        pvalid = 1'b0;
  logic        prd_wr = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic [3:0]  lamp_r, lamp_y, lamp_g;
  logic [2:0]  cur_phase, state;

  int errors = 0;
  int checks = 0;

  tlc_multi #(.NUM_PHASES(4), .CNT_W(16)) dut (
    .pclk(pclk), .prst(prst), .pvalid(pvalid), .prd_wr(prd_wr),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
    .cur_phase(cur_phase), .state(state)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    pvalid = 1'b1; prd_wr = 1'b1; paddr = a; pwdata = d;
    step();
    pvalid = 1'b0; prd_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    pvalid = 1'b1; prd_wr = 1'b0; paddr = a;
    step();
    pvalid = 1'b0;
  endtask

  task automatic do_reset();
    prst = 1'b0;
    repeat (2) step();
    prst = 1'b1;
  endtask

  task automatic prog();
    wr(8'h08, 32'h0005_0003);
    wr(8'h04, 32'h0002_0001);
    wr(8'h00, 32'h0001_0002);
  endtask

  task automatic row(input string tag, input logic [17:0] e);
    chk({tag, "_st"}, 32'(state), 32'(e[17:15]));
    chk({tag, "_ph"}, 32'(cur_phase), 32'(e[14:12]));
    chk({tag, "_r"}, 32'(lamp_r), 32'(e[11:8]));
    chk({tag, "_y"}, 32'(lamp_y), 32'(e[7:4]));
    chk({tag, "_g"}, 32'(lamp_g), 32'(e[3:0]));
  endtask

  logic [17:0] high_t [9] = '{
    {3'd2, 3'd3, 4'hF, 4'h0, 4'h0}, {3'd2, 3'd3, 4'hF, 4'h0, 4'h0},
    {3'd4, 3'd0, 4'hE, 4'h0, 4'h1}, {3'd4, 3'd0, 4'hE, 4'h0, 4'h1},
    {3'd4, 3'd0, 4'hE, 4'h0, 4'h1}, {3'd3, 3'd0, 4'hE, 4'h1, 4'h0},
    {3'd2, 3'd0, 4'hF, 4'h0, 4'h0}, {3'd2, 3'd0, 4'hF, 4'h0, 4'h0},
    {3'd4, 3'd1, 4'hD, 4'h0, 4'h2}
  };

  logic [17:0] low_t [10] = '{
    {3'd2, 3'd3, 4'hF, 4'h0, 4'h0}, {3'd4, 3'd0, 4'hE, 4'h0, 4'h1},
    {3'd4, 3'd0, 4'hE, 4'h0, 4'h1}, {3'd4, 3'd0, 4'hE, 4'h0, 4'h1},
    {3'd4, 3'd0, 4'hE, 4'h0, 4'h1}, {3'd4, 3'd0, 4'hE, 4'h0, 4'h1},
    {3'd3, 3'd0, 4'hE, 4'h1, 4'h0}, {3'd3, 3'd0, 4'hE, 4'h1, 4'h0},
    {3'd2, 3'd0, 4'hF, 4'h0, 4'h0}, {3'd4, 3'd1, 4'hD, 4'h0, 4'h2}
  };

  logic [17:0] blink_t [9] = '{
    {3'd3, 3'd0, 4'h0, 4'hF, 4'h0}, {3'd3, 3'd0, 4'h0, 4'hF, 4'h0},
    {3'd3, 3'd0, 4'h0, 4'hF, 4'h0}, {3'd3, 3'd0, 4'h0, 4'hF, 4'h0},
    {3'd1, 3'd0, 4'h0, 4'h0, 4'h0}, {3'd1, 3'd0, 4'h0, 4'h0, 4'h0},
    {3'd1, 3'd0, 4'h0, 4'h0, 4'h0}, {3'd1, 3'd0, 4'h0, 4'h0, 4'h0},
    {3'd3, 3'd0, 4'h0, 4'hF, 4'h0}
  };

  localparam logic [17:0] RED_ALL_P0 = {3'd2, 3'd0, 4'hF, 4'h0, 4'h0};
  localparam logic [17:0] RED_ALL_P3 = {3'd2, 3'd3, 4'hF, 4'h0, 4'h0};
  localparam logic [17:0] GRN_P0     = {3'd4, 3'd0, 4'hE, 4'h0, 4'h1};
  localparam logic [17:0] YEL_P0     = {3'd3, 3'd0, 4'hE, 4'h1, 4'h0};
  localparam logic [17:0] DARK       = {3'd0, 3'd0, 4'h0, 4'h0, 4'h0};
  localparam logic [17:0] BLK_Y      = {3'd3, 3'd0, 4'h0, 4'hF, 4'h0};
  localparam logic [17:0] BLK_B      = {3'd1, 3'd0, 4'h0, 4'h0, 4'h0};

  initial begin
    // Reset state
    step();
    step();
    row("rst", DARK);
    chk("rst_rdy", 32'(pready), 32'd0);
    chk("rst_rd", prdata, 32'd0);
    prst = 1'b1;
    rd(8'h0C);
    chk("mode_rd", prdata, 32'd0);
    chk("mode_rdy", 32'(pready), 32'd1);
    step();
    chk("rdy_clr", 32'(pready), 32'd0);
    row("idle", DARK);

    // HIGH mode
    prog();
    rd(8'h08);
    chk("grn_rd", prdata, 32'h0005_0003);
    wr(8'h0C, 32'd3);
    for (int i = 0; i < 9; i++) begin
      step();
      row($sformatf("high%0d", i + 1), high_t[i]);
    end
    repeat (17) step();
    row("high26", RED_ALL_P3);
    step();
    row("high27", GRN_P0);
    repeat (3) step();
    row("high30", YEL_P0);
    prst = 1'b0;
    #1;
    row("async_rst", DARK);
    step();
    prst = 1'b1;

    // LOW mode
    prog();
    wr(8'h0C, 32'd4);
    for (int i = 0; i < 10; i++) begin
      step();
      row($sformatf("low%0d", i + 1), low_t[i]);
    end

    // BLINK, period 4 then period 0
    do_reset();
    wr(8'h14, 32'd4);
    wr(8'h0C, 32'd1);
    for (int i = 0; i < 9; i++) begin
      step();
      row($sformatf("blink%0d", i + 1), blink_t[i]);
    end
    do_reset();
    wr(8'h14, 32'd0);
    wr(8'h0C, 32'd1);
    step(); row("bl0_1", BLK_Y);
    step(); row("bl0_2", BLK_B);
    step(); row("bl0_3", BLK_Y);
    step(); row("bl0_4", BLK_B);

    // MANUAL mid-GREEN, register-map corner cases, resume HIGH
    do_reset();
    prog();
    wr(8'h0C, 32'd3);
    repeat (4) step();
    row("man_pre", GRN_P0);
    wr(8'h0C, 32'd2);
    step();
    row("man1", RED_ALL_P0);
    wr(8'h10, 32'hFFFF_FFFF);
    wr(8'h20, 32'h0000_1234);
    rd(8'h10);
    chk("stat_rd", prdata, 32'h0000_0002);
    chk("stat_rdy", 32'(pready), 32'd1);
    rd(8'h20);
    chk("unmap_rd", prdata, 32'd0);
    step();
    chk("man_rdy", 32'(pready), 32'd0);
    row("man2", RED_ALL_P0);
    wr(8'h0C, 32'd3);
    step(); row("res1", RED_ALL_P3);
    step(); row("res2", RED_ALL_P3);
    step(); row("res3", GRN_P0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
